// File: rtl/lsu_stbuf_pkg.sv
// Shared store-buffer types: entry layout, default geometry and the pointer-width helper.
package lsu_stbuf_pkg;

    localparam int STBUF_DEPTH      = 4;
    localparam int STBUF_ADDR_W     = 16;
    localparam int STBUF_DATA_W     = 39;
    localparam int STBUF_STARVE_MAX = 8;

    function automatic int stbuf_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int STBUF_PTR_W = stbuf_ptr_w(STBUF_DEPTH);

    typedef struct packed {
        logic                    valid;
        logic [STBUF_ADDR_W-1:2] addr;
        logic [STBUF_DATA_W-1:0] data;
    } stbuf_entry_t;

endpackage

// File: rtl/lsu_stbuf_fwd.sv
// Youngest-first forwarding match across the occupied store-buffer slots (head .. head+count-1).
module lsu_stbuf_fwd
    import lsu_stbuf_pkg::*;
#(
    parameter int DEPTH  = STBUF_DEPTH,
    parameter int ADDR_W = STBUF_ADDR_W,
    parameter int DATA_W = STBUF_DATA_W,
    parameter int PTR_W  = STBUF_PTR_W
) (
    input  stbuf_entry_t      entries [DEPTH],
    input  logic [PTR_W-1:0]  head,
    input  logic [PTR_W:0]    count,
    input  logic [ADDR_W-1:2] ld_word,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    logic [PTR_W-1:0] idx_s;
    logic             match_s;

    // Walk oldest to youngest so a younger match overrides any older one.
    always_comb begin
        hit     = 1'b0;
        data    = {DATA_W{1'b0}};
        idx_s   = head;
        match_s = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_s   = head + PTR_W'(k);
            match_s = ((PTR_W + 1)'(k) < count) & entries[idx_s].valid
                      & (entries[idx_s].addr == ld_word);
            hit     = hit | match_s;
            data    = match_s ? entries[idx_s].data : data;
        end
    end

endmodule

// File: rtl/lsu_dccm_stbuf.sv
// Store buffer in front of the DCCM write port: in-order queue, tail coalescing, idle-cycle drain.
// Build option LSU_STBUF_FWD_EN: forward buffered data to loads; otherwise matching loads stall.
module lsu_dccm_stbuf
    import lsu_stbuf_pkg::*;
#(
    parameter int DEPTH      = STBUF_DEPTH,
    parameter int ADDR_W     = STBUF_ADDR_W,
    parameter int DATA_W     = STBUF_DATA_W,
    parameter int STARVE_MAX = STBUF_STARVE_MAX
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   st_valid,
    output logic                   st_ready,
    input  logic [ADDR_W-1:0]      st_addr,
    input  logic [DATA_W-1:0]      st_data,
    input  logic                   ld_rden,
    input  logic [ADDR_W-1:0]      ld_addr,
    output logic                   ld_stall,
    output logic                   fwd_hit,
    output logic [DATA_W-1:0]      fwd_data,
    input  logic                   flush_req,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   dccm_wren,
    output logic [ADDR_W-1:0]      dccm_wr_addr,
    output logic [DATA_W-1:0]      dccm_wr_data
);

    localparam int PTR_W    = stbuf_ptr_w(DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    stbuf_entry_t        entries_r [DEPTH];
    logic [PTR_W-1:0]    head_r;
    logic [PTR_W-1:0]    tail_r;
    logic [PTR_W-1:0]    youngest_s;
    logic [CNT_W-1:0]    count_r;
    logic [CNT_W-1:0]    count_nxt_s;
    logic [STARVE_W-1:0] starve_r;
    logic [STARVE_W-1:0] starve_nxt_s;
    logic [ADDR_W-1:2]   st_word_s;
    logic [ADDR_W-1:2]   ld_word_s;
    logic                full_s;
    logic                nonempty_s;
    logic                drain_s;
    logic                accept_s;
    logic                coalesce_s;
    logic                push_s;
    logic                starve_max_s;
    logic                match_stall_s;
    logic                fwd_hit_s;
    logic [DATA_W-1:0]   fwd_data_s;
    logic                unused_s;

    assign st_word_s    = st_addr[ADDR_W-1:2];
    assign ld_word_s    = ld_addr[ADDR_W-1:2];
    assign unused_s     = ^{st_addr[1:0], ld_addr[1:0]};

    assign full_s       = (count_r == CNT_W'(DEPTH));
    assign nonempty_s   = (count_r != {CNT_W{1'b0}});
    assign drain_s      = ~rst & nonempty_s & ~ld_rden & ~freeze;
    assign st_ready     = ~rst & ~flush_req & ~full_s;
    assign accept_s     = st_valid & st_ready;
    assign youngest_s   = tail_r - PTR_W'(1);

    // The youngest entry is only popping when it is also the head, i.e. a single occupant.
    assign coalesce_s   = accept_s & nonempty_s
                          & (entries_r[youngest_s].addr == st_word_s)
                          & ~(drain_s & (count_r == CNT_W'(1)));
    assign push_s       = accept_s & ~coalesce_s;

    assign starve_max_s = (starve_r == STARVE_W'(STARVE_MAX));

    // Occupancy after this cycle's push and pop.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, drain_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Starvation: counts consecutive full cycles lost to loads, saturating at the stall threshold.
    always_comb begin
        starve_nxt_s = starve_r;
        if (~full_s | drain_s) begin
            starve_nxt_s = {STARVE_W{1'b0}};
        end else if (ld_rden & ~freeze & ~starve_max_s) begin
            starve_nxt_s = starve_r + STARVE_W'(1);
        end else begin
            starve_nxt_s = starve_r;
        end
    end

    // Entry storage, ring pointers, occupancy and starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= '{valid: 1'b0, addr: {(ADDR_W-2){1'b0}}, data: {DATA_W{1'b0}}};
            end
            head_r   <= {PTR_W{1'b0}};
            tail_r   <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            starve_r <= {STARVE_W{1'b0}};
        end else begin
            if (drain_s) begin
                entries_r[head_r].valid <= 1'b0;
                head_r                  <= head_r + PTR_W'(1);
            end
            if (push_s) begin
                entries_r[tail_r] <= '{valid: 1'b1, addr: st_word_s, data: st_data};
                tail_r            <= tail_r + PTR_W'(1);
            end
            if (coalesce_s) begin
                entries_r[youngest_s].data <= st_data;
            end
            count_r  <= count_nxt_s;
            starve_r <= starve_nxt_s;
        end
    end

`ifdef LSU_STBUF_FWD_EN
    lsu_stbuf_fwd #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_fwd (
        .entries (entries_r),
        .head    (head_r),
        .count   (count_r),
        .ld_word (ld_word_s),
        .hit     (fwd_hit_s),
        .data    (fwd_data_s)
    );

    assign match_stall_s = 1'b0;
`else
    assign fwd_hit_s  = 1'b0;
    assign fwd_data_s = {DATA_W{1'b0}};

    // Without forwarding a load that hits any buffered word must wait for it to drain.
    always_comb begin
        match_stall_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            match_stall_s = match_stall_s
                            | (entries_r[i].valid & (entries_r[i].addr == ld_word_s));
        end
    end
`endif

    assign fwd_hit      = ~rst & fwd_hit_s;
    assign fwd_data     = {DATA_W{~rst}} & fwd_data_s;
    assign ld_stall     = ~rst & (starve_max_s | (ld_rden & match_stall_s));
    assign dccm_wren    = drain_s;
    assign dccm_wr_addr = {entries_r[head_r].addr, 2'b00};
    assign dccm_wr_data = entries_r[head_r].data;
    assign count        = count_r;
    assign empty        = ~nonempty_s;

endmodule

// File: tb/tb_lsu_dccm_stbuf.sv
// Scoreboard bench for lsu_dccm_stbuf: queue-based reference model, directed scenarios, random traffic.
module tb_lsu_dccm_stbuf;

    localparam int DEPTH      = 4;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 39;
    localparam int STARVE_MAX = 8;
    localparam int CNT_W      = 3;
`ifdef LSU_STBUF_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, freeze, st_valid, st_ready, ld_rden, ld_stall, fwd_hit;
    logic              flush_req, empty, dccm_wren;
    logic [ADDR_W-1:0] st_addr, ld_addr, dccm_wr_addr;
    logic [DATA_W-1:0] st_data, fwd_data, dccm_wr_data;
    logic [CNT_W-1:0]  count;

    lsu_dccm_stbuf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .ld_rden(ld_rden), .ld_addr(ld_addr),
        .ld_stall(ld_stall), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .flush_req(flush_req),
        .empty(empty), .count(count), .dccm_wren(dccm_wren), .dccm_wr_addr(dccm_wr_addr),
        .dccm_wr_data(dccm_wr_data)
    );

    always #5 clk = ~clk;

    typedef struct { int unsigned word; logic [DATA_W-1:0] data; } ment_t;
    typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_t;
    typedef struct {
        logic rst, ready, stall, hit, wren, empty;
        logic [DATA_W-1:0] fdata;
        logic [CNT_W-1:0]  cnt;
    } cyc_t;

    ment_t mq[$];
    wr_t   exp_wr_q[$];
    cyc_t  exp_cyc_q[$];
    int    starve = 0;
    bit    stall_prev = 1'b0;
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides this cycle's expected outputs and DCCM write.
    task automatic cycle(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic rd, input logic [ADDR_W-1:0] la, input logic frz,
                         input logic fl, input logic r);
        cyc_t        e;
        wr_t         w;
        ment_t       m;
        int          cnt;
        bit          drain, match;
        int unsigned lw, sw;
        @(posedge clk);
        #1;
        rd = rd & ~stall_prev;
        st_valid = v; st_addr = a; st_data = d; ld_rden = rd; ld_addr = la;
        freeze = frz; flush_req = fl; rst = r;
        e.rst = r; e.ready = 1'b0; e.stall = 1'b0; e.hit = 1'b0; e.wren = 1'b0;
        e.empty = 1'b1; e.fdata = '0; e.cnt = '0;
        if (r) begin
            mq.delete();
            starve = 0;
            stall_prev = 1'b0;
        end else begin
            cnt   = mq.size();
            drain = (cnt > 0) && !rd && !frz;
            lw    = 32'(la[ADDR_W-1:2]);
            sw    = 32'(a[ADDR_W-1:2]);
            match = 1'b0;
            foreach (mq[i]) begin
                if (mq[i].word == lw) begin
                    match = 1'b1;
                    e.fdata = mq[i].data;
                end
            end
            e.ready = !fl && (cnt < DEPTH);
            e.stall = (starve == STARVE_MAX) || (!FWD && rd && match);
            e.hit   = FWD ? match : 1'b0;
            if (!FWD) e.fdata = '0;
            e.wren  = drain;
            e.cnt   = CNT_W'(cnt);
            e.empty = (cnt == 0);
            if (drain) begin
                m = mq.pop_front();
                w.addr = ADDR_W'(m.word << 2);
                w.data = m.data;
                exp_wr_q.push_back(w);
            end
            if (v && e.ready) begin
                if (mq.size() > 0 && mq[$].word == sw) begin
                    mq[$].data = d;
                end else begin
                    m.word = sw;
                    m.data = d;
                    mq.push_back(m);
                end
            end
            if (cnt < DEPTH || drain) starve = 0;
            else if (rd && !frz && starve < STARVE_MAX) starve++;
            stall_prev = e.stall;
        end
        exp_cyc_q.push_back(e);
    endtask

    task automatic st(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic rd);
        cycle(1'b1, a, d, rd, 16'h0100, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic rd, input logic [ADDR_W-1:0] la);
        cycle(1'b0, 16'h0000, '0, rd, la, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compares every presented cycle and every DCCM write against the scoreboard.
    always @(negedge clk) begin
        cyc_t e;
        wr_t  w;
        if (exp_cyc_q.size() > 0) begin
            e = exp_cyc_q.pop_front();
            chk("st_ready", 64'(st_ready), 64'(e.ready));
            chk("ld_stall", 64'(ld_stall), 64'(e.stall));
            chk("fwd_hit", 64'(fwd_hit), 64'(e.hit));
            chk("dccm_wren", 64'(dccm_wren), 64'(e.wren));
            if (!e.rst) begin
                chk("fwd_data", 64'(fwd_data), 64'(e.fdata));
                chk("count", 64'(count), 64'(e.cnt));
                chk("empty", 64'(empty), 64'(e.empty));
            end
            if (dccm_wren === 1'b1) begin
                if (exp_wr_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL dccm_write: unexpected write addr %0h data %0h, none expected",
                             dccm_wr_addr, dccm_wr_data);
                end else begin
                    w = exp_wr_q.pop_front();
                    chk("wr_addr", 64'(dccm_wr_addr), 64'(w.addr));
                    chk("wr_data", 64'(dccm_wr_data), 64'(w.data));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; freeze = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_rden = 1'b0; ld_addr = '0; flush_req = 1'b0;

        // 1: three stores drain on consecutive cycles
        cycle(1'b0, 16'h0, '0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0, '0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        st(16'h0010, 39'h00_0000_0010, 1'b0);
        st(16'h0014, 39'h00_0000_0014, 1'b0);
        st(16'h0018, 39'h00_0000_0018, 1'b0);
        repeat (3) idle(1'b0, 16'h0100);

        // 2: fill under continuous loads, starve, forced stall, then drain
        st(16'h0010, 39'h01_0000_0010, 1'b1);
        st(16'h0014, 39'h01_0000_0014, 1'b1);
        st(16'h0018, 39'h01_0000_0018, 1'b1);
        st(16'h001C, 39'h01_0000_001C, 1'b1);
        repeat (12) st(16'h0040, 39'h7F_FFFF_FFFF, 1'b1);
        repeat (6) idle(1'b0, 16'h0100);

        // 3: back-to-back same-address stores coalesce
        st(16'h0020, 39'h0A_AAAA_AAAA, 1'b1);
        st(16'h0022, 39'h0B_BBBB_BBBB, 1'b1);
        repeat (3) idle(1'b0, 16'h0100);

        // 4: forwarding picks the youngest match
        st(16'h0030, 39'h0C_CCCC_CCCC, 1'b1);
        st(16'h0034, 39'h0D_DDDD_DDDD, 1'b1);
        st(16'h0030, 39'h0E_EEEE_EEEE, 1'b1);
        idle(1'b1, 16'h0030);
        idle(1'b1, 16'h0038);
        repeat (5) idle(1'b0, 16'h0030);

        // 5: full buffer pops but refuses the push
        for (int i = 0; i < 4; i++) st(16'(16'h0050 + 4 * i), 39'(i + 5), 1'b1);
        st(16'h0070, 39'h12_3456_789A, 1'b0);
        repeat (5) idle(1'b0, 16'h0100);

        // 6: flush drains and refuses stores; reset mid-drain
        st(16'h0080, 39'h00_0000_0080, 1'b1);
        st(16'h0084, 39'h00_0000_0084, 1'b1);
        repeat (3) cycle(1'b1, 16'h0088, 39'h1, 1'b0, 16'h0100, 1'b0, 1'b1, 1'b0);
        st(16'h0090, 39'h00_0000_0090, 1'b1);
        st(16'h0094, 39'h00_0000_0094, 1'b1);
        cycle(1'b0, 16'h0, '0, 1'b0, 16'h0100, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 16'h0, '0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);
        idle(1'b0, 16'h0100);
        idle(1'b0, 16'h0100);

        // Random traffic over a small word set so coalescing and matches are common
        for (int n = 0; n < 3000; n++) begin
            logic [ADDR_W-1:0] a, la;
            logic [DATA_W-1:0] d;
            int rd_pct;
            a  = {8'h00, 3'b010, 3'($urandom_range(0, 7)), 2'($urandom)};
            la = {8'h00, 3'b010, 3'($urandom_range(0, 7)), 2'($urandom)};
            d  = {7'($urandom), 32'($urandom)};
            rd_pct = (((n / 100) % 3) == 1) ? 95 : 50;
            cycle($urandom_range(0, 99) < 60, a, d, $urandom_range(0, 99) < rd_pct, la,
                  $urandom_range(0, 99) < 8, ((n / 40) % 5) == 3, $urandom_range(0, 999) < 5);
        end
        repeat (8) idle(1'b0, 16'h0100);

        @(negedge clk);
        #1;
        chk("pending_writes", 64'(exp_wr_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
